// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: command word layout,
// opcode encodings and the sequencer state type.
package alu_pkg;

  localparam int CMD_W = 18;

  localparam int OP_MSB = 17;
  localparam int OP_LSB = 16;
  localparam int A_MSB  = 15;
  localparam int A_LSB  = 12;
  localparam int B_MSB  = 11;
  localparam int B_LSB  = 8;
  localparam int C_MSB  = 7;
  localparam int C_LSB  = 4;
  localparam int D_MSB  = 3;
  localparam int D_LSB  = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_BAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } seq_state_t;

  // A word is forwarded to the ALU only if its opcode is one the ALU implements.
  function automatic logic is_legal(input logic [CMD_W-1:0] cmd);
    return cmd[OP_MSB:OP_LSB] != OP_BAD;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command-side handshake and ALU-side load bus of the sequencer.
// master = producer/ALU observer view, slave = sequencer view.
interface alu_cmd_sequencer_if;
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [CMD_W-1:0] in_data;
  logic [CMD_W-1:0] alu_data;
  logic             alu_load;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  alu_data,
    input  alu_load
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output alu_data,
    output alu_load
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate occupancy register.
module cmd_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Callers must not push when full nor pop when empty; guard anyway so a
  // stray strobe cannot corrupt the pointers.
  logic do_push;
  logic do_pop;

  // Qualified push/pop strobes.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; contents are only visible through rd_ptr.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Status and head-of-queue read.
  always_comb begin
    count   = wr_ptr - rd_ptr;
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_data = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, drops illegal opcodes, and issues the rest to the
// ALU as a held data word plus a one-cycle load pulse, spaced by GAP idle
// cycles so the ALU finishes each operation first.
//
// state | meaning
// IDLE  | nothing issued recently; pops as soon as the FIFO is non-empty
// LOAD  | alu_load high for this single cycle; gap timer armed to GAP-1
// WAIT  | gap timer counting down; at zero pop next command or fall idle
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_cmd_sequencer_if.slave      bus,
  output logic                    busy,
  output logic                    err,
  output logic [7:0]              err_count,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [GW-1:0]    gap_cnt;
  logic             pop;
  logic             push;
  logic             accept;
  logic             full;
  logic             empty;
  logic [CMD_W-1:0] head;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (bus.in_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Intake: ready depends on occupancy only; illegal words are accepted but not stored.
  always_comb begin
    bus.in_ready = !full;
    accept       = bus.in_valid && !full;
    push         = accept && is_legal(bus.in_data);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, pop decision and load strobe.
  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    bus.alu_load = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        bus.alu_load = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (gap_cnt == '0) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gap down-counter: armed in LOAD, decremented while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (state == LOAD) begin
      gap_cnt <= GW'(GAP - 1);
    end else if (state == WAIT && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // ALU data word changes only when a command is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      bus.alu_data <= '0;
    else if (pop) bus.alu_data <= head;
  end

  // Illegal-opcode flag and saturating reject counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= accept && !is_legal(bus.in_data);
      if (accept && !is_legal(bus.in_data) && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Busy whenever work is in flight or queued.
  always_comb begin
    busy = (state != IDLE) || !empty;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer against a
// cycle-level behavioural model built from a command queue and the
// time of the last issued load.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int GAP   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic          err;
  logic [7:0]    err_count;
  logic [CW-1:0] count;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(
    .DEPTH (DEPTH),
    .GAP   (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err       (err),
    .err_count (err_count),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [17:0] q[$];
  logic [17:0] data_exp = '0;
  logic        load_exp = 1'b0;
  logic        err_exp  = 1'b0;
  int          errcnt_exp = 0;
  bit          have_load = 0;
  int          last_load = 0;
  int          cyc = 0;
  int          load_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
    end
  endtask

  task automatic model_reset();
    q.delete();
    data_exp   = '0;
    load_exp   = 1'b0;
    err_exp    = 1'b0;
    errcnt_exp = 0;
    have_load  = 0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model over the edge.
  // Called just after a falling edge.
  task automatic step(input logic v, input logic [17:0] d, output logic acc);
    bit do_pop;
    bit busy_exp;
    if (bus.alu_load === 1'b1) load_log.push_back(cyc);
    busy_exp = (q.size() != 0) || (have_load && (cyc - last_load) <= GAP);
    check_eq("in_ready",  32'(bus.in_ready), 32'(q.size() < DEPTH));
    check_eq("count",     32'(count),        32'(q.size()));
    check_eq("alu_load",  32'(bus.alu_load), 32'(load_exp));
    check_eq("alu_data",  32'(bus.alu_data), 32'(data_exp));
    check_eq("err",       32'(err),          32'(err_exp));
    check_eq("err_count", 32'(err_count),    32'(errcnt_exp));
    check_eq("busy",      32'(busy),         32'(busy_exp));
    bus.in_valid = v;
    bus.in_data  = d;
    do_pop = (q.size() != 0) && (!have_load || (cyc - last_load) >= GAP);
    acc    = v && (q.size() < DEPTH);
    @(posedge clk);
    load_exp = do_pop;
    if (do_pop) begin
      data_exp  = q.pop_front();
      have_load = 1;
      last_load = cyc + 1;
    end
    err_exp = acc && (d[17:16] == 2'b11);
    if (err_exp && errcnt_exp < 255) errcnt_exp++;
    if (acc && d[17:16] != 2'b11) q.push_back(d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 18'h0, a);
  endtask

  // Asynchronous reset asserted in the middle of the low clock phase.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_alu_load",  32'(bus.alu_load), 32'd0);
    check_eq("rst_alu_data",  32'(bus.alu_data), 32'd0);
    check_eq("rst_err",       32'(err),          32'd0);
    check_eq("rst_err_count", 32'(err_count),    32'd0);
    check_eq("rst_busy",      32'(busy),         32'd0);
    check_eq("rst_count",     32'(count),        32'd0);
    check_eq("rst_in_ready",  32'(bus.in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic        a;
    logic [17:0] burst [5];
    logic [17:0] d;
    int          k;
    int          guard;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);
    do_reset();

    // Single add from idle.
    step(1'b1, 18'h01234, a);
    idle(GAP + 4);

    // Illegal opcode: flagged and counted, never loaded.
    step(1'b1, 18'h3FFFF, a);
    idle(4);

    // Back-to-back burst; hold each word until the sequencer accepts it.
    burst[0] = 18'h0_1111; burst[1] = 18'h1_2222; burst[2] = 18'h2_3333;
    burst[3] = 18'h0_4444; burst[4] = 18'h1_5555;
    load_log.delete();
    k = 0;
    guard = 0;
    while (k < 5 && guard < 100) begin
      step(1'b1, burst[k], a);
      if (a) k++;
      guard++;
    end
    check_eq("burst_accepted", 32'(k), 32'd5);
    guard = 0;
    while (load_log.size() < 5 && guard < 100) begin
      idle(1);
      guard++;
    end
    check_eq("burst_loads", 32'(load_log.size()), 32'd5);
    for (int i = 1; i < 5 && i < load_log.size(); i++)
      check_eq("burst_spacing", 32'(load_log[i] - load_log[i-1]), 32'(GAP + 1));
    idle(GAP + 2);

    // Reset while in WAIT with two commands queued.
    step(1'b1, 18'h0_0AAA, a);
    step(1'b1, 18'h1_0BBB, a);
    step(1'b1, 18'h2_0CCC, a);
    idle(2);
    check_eq("pre_reset_count", 32'(count), 32'd2);
    do_reset();
    load_log.delete();
    idle(3 * GAP);
    check_eq("post_reset_loads", 32'(load_log.size()), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      d = 18'($urandom);
      d[17:16] = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 99) < 45), d, a);
    end
    idle(2 * GAP);

    // Saturation of the reject counter.
    for (int i = 0; i < 300; i++) step(1'b1, 18'h3_0000 | 18'($urandom_range(0, 65535)), a);
    idle(3);
    check_eq("err_sat", 32'(err_count), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
